// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver with Wishbone register access.
// Optional receive FIFO is selected by the UART_RX_FIFO_EN macro (see uart_rx_wb).
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    localparam logic [1:0] REG_RXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;

    localparam int STAT_NE   = 0;
    localparam int STAT_FULL = 1;
    localparam int STAT_OVR  = 2;
    localparam int STAT_FERR = 3;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO. DEPTH must be a power of two so the pointers wrap
// naturally. A push while full is accepted only if a pop happens in the same cycle.
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_wb.sv
// UART receiver: 2-flop input synchroniser, receive FSM, byte buffer and a
// Wishbone slave exposing RXDATA and STATUS. Define UART_RX_FIFO_EN to buffer
// FIFO_DEPTH bytes; otherwise a single holding register is used.
module uart_rx_wb
    import uart_rx_pkg::*;
#(
    parameter int SYS_CLK_FREQ = 80000000,
    parameter int BAUD         = 115200,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_stall_o,
    output logic        wb_err_o,
    input  logic        rx_i,
    output logic        uart_rx_irq,
    output logic [7:0]  uart_rx_byte
);

    localparam int CLKS_PER_BIT = SYS_CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);

    rx_state_t     state;
    rx_state_t     state_next;
    logic          rx_meta;
    logic          rx_sync;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          half_tick;
    logic          full_tick;
    logic          cnt_clr;
    logic          bit_clr;
    logic          shift_en;
    logic          byte_ok;
    logic          ferr_set;

    logic          push;
    logic [7:0]    push_data;
    logic          pop;
    logic          buf_full;
    logic          buf_ne;
    logic [7:0]    buf_head;

    logic          wb_req;
    logic          rd_rxdata;
    logic          wr_status;
    logic [31:0]   rd_data;
    logic [3:0]    status;
    logic          ovr;
    logic          ferr;
    logic          ovr_set;
    logic          unused_bits;

    assign wb_stall_o = 1'b0;
    assign wb_err_o   = 1'b0;

    assign half_tick = (cnt == CW'(HALF_BIT - 1));
    assign full_tick = (cnt == CW'(CLKS_PER_BIT - 1));

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_sync <= rx_meta;
        end
    end

    // Receive FSM state register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Receive FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (!rx_sync) state_next = START;
            START:     if (half_tick) state_next = rx_sync ? IDLE : DATA;
            DATA:      if (full_tick && bit_cnt == 3'd7) state_next = STOP;
            STOP:      if (full_tick) state_next = rx_sync ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (rx_sync) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Receive FSM outputs: counter control, shift strobes and frame result.
    always_comb begin
        cnt_clr  = 1'b1;
        bit_clr  = 1'b0;
        shift_en = 1'b0;
        byte_ok  = 1'b0;
        ferr_set = 1'b0;
        case (state)
            IDLE:  bit_clr = ~rx_sync;
            START: cnt_clr = half_tick;
            DATA: begin
                cnt_clr  = full_tick;
                shift_en = full_tick;
            end
            STOP: begin
                cnt_clr  = full_tick;
                byte_ok  = full_tick & rx_sync;
                ferr_set = full_tick & ~rx_sync;
            end
            default: cnt_clr = 1'b1;
        endcase
    end

    // Bit timing counter, data shift register and the byte/irq outputs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt          <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            uart_rx_irq  <= 1'b0;
            uart_rx_byte <= '0;
        end else begin
            cnt <= cnt_clr ? '0 : cnt + CW'(1);
            if (bit_clr) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (shift_en) begin
                shift_reg <= {rx_sync, shift_reg[7:1]};
            end
            uart_rx_irq <= byte_ok;
            if (byte_ok) begin
                uart_rx_byte <= shift_reg;
            end
        end
    end

    // The buffer is written from the registered byte during the irq cycle.
    assign push      = uart_rx_irq;
    assign push_data = uart_rx_byte;

`ifdef UART_RX_FIFO_EN
    logic buf_empty;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .full      (buf_full),
        .empty     (buf_empty),
        .head      (buf_head)
    );

    assign buf_ne      = ~buf_empty;
    assign unused_bits = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0],
                           wb_dat_i[31:4], wb_dat_i[1:0]};
`else
    logic       hold_valid;
    logic [7:0] hold_data;

    // Single holding register behaving as a depth-1 FIFO.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (push && (!hold_valid || pop)) begin
            hold_valid <= 1'b1;
            hold_data  <= push_data;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end

    assign buf_full    = hold_valid;
    assign buf_ne      = hold_valid;
    assign buf_head    = hold_data;
    assign unused_bits = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0],
                           wb_dat_i[31:4], wb_dat_i[1:0], FIFO_DEPTH[0]};
`endif

    assign ovr_set = push & buf_full & ~pop;

    assign wb_req    = wb_cyc_i & wb_stb_i;
    assign rd_rxdata = wb_req & ~wb_we_i & (wb_adr_i[3:2] == REG_RXDATA);
    assign wr_status = wb_req &  wb_we_i & (wb_adr_i[3:2] == REG_STATUS);

    // STATUS word assembled from buffer state and sticky flags.
    always_comb begin
        status            = '0;
        status[STAT_NE]   = buf_ne;
        status[STAT_FULL] = buf_full;
        status[STAT_OVR]  = ovr;
        status[STAT_FERR] = ferr;
    end

    // Read data mux; unmapped registers and writes read as zero.
    always_comb begin
        rd_data = '0;
        if (wb_req && !wb_we_i) begin
            case (wb_adr_i[3:2])
                REG_RXDATA: rd_data = {24'b0, buf_ne ? buf_head : 8'h00};
                REG_STATUS: rd_data = {28'b0, status};
                default:    rd_data = '0;
            endcase
        end
    end

    // Registered Wishbone response; the RXDATA pop lands on the ack cycle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            pop      <= 1'b0;
        end else begin
            wb_ack_o <= wb_req;
            wb_dat_o <= rd_data;
            pop      <= rd_rxdata & buf_ne;
        end
    end

    // Sticky error flags, write-1-to-clear, with a new event beating the clear.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ovr  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            if (ovr_set) begin
                ovr <= 1'b1;
            end else if (wr_status && wb_dat_i[STAT_OVR]) begin
                ovr <= 1'b0;
            end
            if (ferr_set) begin
                ferr <= 1'b1;
            end else if (wr_status && wb_dat_i[STAT_FERR]) begin
                ferr <= 1'b0;
            end
        end
    end

endmodule
